fetch_pc_unit: RTL and testbench

Program-counter and next-PC generation stage directly upstream of the instruction memory in the single-cycle RISC-V core. Holds the architectural PC, drives it combinationally into the instruction memory each cycle, and selects the next PC from sequential, branch, JAL or JALR targets. Also handles stall, halt/resume and (optionally) misaligned-target traps.

---
 rtl/core_pkg.sv | 18 +
 rtl/next_pc_mux.sv | 24 ++
 rtl/fetch_pc_unit.sv | 101 ++++++++++
 tb/tb_fetch_pc_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: pc_sel encodings, fetch FSM states, default vectors.
package core_pkg;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JAL  = 2'b10;
    localparam logic [1:0] PC_JALR = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC target selection plus misalignment detect.
module next_pc_mux
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        target = pc + 32'd4;
        case (pc_sel)
            PC_SEQ:         target = pc + 32'd4;
            PC_BR, PC_JAL:  target = pc + imm;
            PC_JALR:        target = (rs1 + imm) & ~32'd1;
            default:        target = pc + 32'd4;
        endcase
        misaligned = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch FSM (BOOT/RUN/HALT) and next-PC update.
// Define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR.
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        trap,
    output logic [31:0] bad_addr
);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         trap_q, trap_d;
    logic [31:0]  bad_addr_q, bad_addr_d;

    logic [31:0]  target;
    logic         misaligned;

    next_pc_mux u_next_pc_mux (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .imm        (imm),
        .rs1        (rs1),
        .target     (target),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        trap_d     = 1'b0;
        bad_addr_d = bad_addr_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (TRAP_EN && misaligned) begin
                    pc_d       = TRAP_VECTOR;
                    trap_d     = 1'b1;
                    bad_addr_d = target;
                end else begin
                    // Aligned targets pass unchanged; without trapping, low bits are dropped.
                    pc_d = {target[31:2], 2'b00};
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            trap_q     <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            trap_q     <= trap_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign trap        = trap_q;
    assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; expectations follow MISALIGN_TRAP_EN if defined.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_sel;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        stall;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        trap;
    logic [31:0] bad_addr;

    int n_pass  = 0;
    int n_total = 0;

    fetch_pc_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0080)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .imm         (imm),
        .rs1         (rs1),
        .stall       (stall),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .trap        (trap),
        .bad_addr    (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_sel = 2'b00; imm = '0; rs1 = '0;
        stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
        #2;
        check("rst_pc",       pc,          32'h0);
        check("rst_pc_plus4", pc_plus4,    32'h4);
        check("rst_fv",       fetch_valid, 32'h0);
        check("rst_halted",   halted,      32'h0);
        check("rst_trap",     trap,        32'h0);
        check("rst_bad_addr", bad_addr,    32'h0);

        @(negedge clk); rst_n = 1'b1;
        #1;
        check("boot_pc", pc,          32'h0);
        check("boot_fv", fetch_valid, 32'h0);
        tick();
        check("run0_pc", pc,          32'h0);
        check("run0_fv", fetch_valid, 32'h1);
        tick();
        check("seq_pc4", pc, 32'h4);

        repeat (6) tick();
        check("seq_pc1c", pc, 32'h1C);

        pc_sel = 2'b01; imm = 32'h30;
        tick();
        check("br_pc", pc, 32'h4C);

        pc_sel = 2'b10; imm = 32'hFFFF_FFF8;
        tick();
        check("jal_pc",       pc,       32'h44);
        check("jal_pc_plus4", pc_plus4, 32'h48);

        pc_sel = 2'b11; rs1 = 32'h103; imm = 32'h0;
        tick();
`ifdef MISALIGN_TRAP_EN
        check("jalr_mis_pc",   pc,       32'h80);
        check("jalr_mis_trap", trap,     32'h1);
        check("jalr_mis_bad",  bad_addr, 32'h102);
`else
        check("jalr_mis_pc",   pc,       32'h100);
        check("jalr_mis_trap", trap,     32'h0);
        check("jalr_mis_bad",  bad_addr, 32'h0);
`endif

        pc_sel = 2'b00;
        tick();
        check("trap_clear", trap, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("after_trap_pc", pc, 32'h84);
`else
        check("after_trap_pc", pc, 32'h104);
`endif

        pc_sel = 2'b01; imm = 32'h2;
        tick();
`ifdef MISALIGN_TRAP_EN
        check("br_mis_pc",   pc,       32'h80);
        check("br_mis_trap", trap,     32'h1);
        check("br_mis_bad",  bad_addr, 32'h86);
`else
        check("br_mis_pc",   pc,       32'h104);
        check("br_mis_trap", trap,     32'h0);
        check("br_mis_bad",  bad_addr, 32'h0);
`endif

        pc_sel = 2'b11; rs1 = 32'h40; imm = 32'h0;
        tick();
        check("jalr_pc40",   pc,   32'h40);
        check("jalr_ntrap",  trap, 32'h0);

        stall = 1'b1; halt_req = 1'b1; pc_sel = 2'b01; imm = 32'h30;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",     pc,          32'h40);
            check("stall_halted", halted,      32'h0);
            check("stall_fv",     fetch_valid, 32'h1);
        end

        stall = 1'b0;
        tick();
        check("halt_pc",     pc,          32'h40);
        check("halt_halted", halted,      32'h1);
        check("halt_fv",     fetch_valid, 32'h0);

        halt_req = 1'b0; stall = 1'b1;
        tick();
        check("halt_hold_pc",     pc,     32'h40);
        check("halt_hold_halted", halted, 32'h1);

        stall = 1'b0; resume = 1'b1;
        tick();
        check("resume_pc",     pc,          32'h44);
        check("resume_fv",     fetch_valid, 32'h1);
        check("resume_halted", halted,      32'h0);
        resume = 1'b0;

        pc_sel = 2'b11; rs1 = 32'hFFFF_FFFC; imm = 32'h0;
        tick();
        check("top_pc",       pc,       32'hFFFF_FFFC);
        check("top_pc_plus4", pc_plus4, 32'h0);
        pc_sel = 2'b00;
        tick();
        check("wrap_pc", pc, 32'h0);

        pc_sel = 2'b10; imm = 32'h44;
        tick();
        check("pre_rst_pc", pc, 32'h44);
        pc_sel = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",  pc,          32'h0);
        check("async_rst_fv",  fetch_valid, 32'h0);
        check("async_rst_p4",  pc_plus4,    32'h4);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("reboot_fv", fetch_valid, 32'h0);
        tick();
        check("rerun_fv", fetch_valid, 32'h1);
        check("rerun_pc", pc,          32'h0);
        tick();
        check("rerun_pc4", pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
